sdram_arbiter: RTL and testbench
================================

SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1024: max cycles from ctrl_acc_o rise to ctrl_ack_i before timeout; 0 disables the timeout.
REQ-002 SHALL have one clock; reset is synchronous and active-high; ports are named sdram_clk and sdram_rst.
REQ-003 sdram_clk  in  1  sole clock; all state updates on rising edge.
REQ-004 sdram_rst  in  1  synchronous active-high reset.
REQ-005 mN_acc_i  in  1  (N=0,1) port N request; held high until mN_ack_o is seen.
REQ-006 mN_we_i  in  1  port N write when 1, read when 0.
REQ-007 mN_adr_i  in  32  port N byte address.
REQ-008 mN_dat_i  in  16  port N write data.
REQ-009 mN_sel_i  in  2  port N byte selects.
REQ-010 mN_dat_o  out  16  port N read data.
REQ-011 mN_ack_o  out  1  port N one-cycle completion pulse.
REQ-012 ctrl_idle_i  in  1  controller ready for a new access.
REQ-013 ctrl_ack_i  in  1  controller one-cycle completion pulse.
REQ-014 ctrl_dat_i  in  16  controller read data, valid with ctrl_ack_i.
REQ-015 ctrl_acc_o, ctrl_we_o  out  1 each  request/write strobe to controller.
REQ-016 ctrl_adr_o  out  32;  ctrl_dat_o  out  16;  ctrl_sel_o  out  2  latched request fields.
REQ-017 grant_o  out  2  one-hot owner of the current access; 00 when none.
REQ-018 timeout_o  out  1  sticky flag, set on any access exceeding TIMEOUT.

Function
REQ-019 SHALL implement states IDLE, ISSUE, WAIT_ACK.
REQ-020 IDLE: when ctrl_idle_i=1 and at least one mN_acc_i=1, SHALL select a winner, latch its adr/dat/sel/we into ctrl_* outputs, set grant_o, and go to ISSUE.
REQ-021 Arbitration SHALL be round-robin: with both requesting, the port not granted last wins; with one requesting, that port wins; the last-grant pointer resets to 1, so port 0 wins the first contention.
REQ-022 ISSUE: SHALL assert ctrl_acc_o=1 and go to WAIT_ACK; request latency from mN_acc_i rise to ctrl_acc_o rise is 2 cycles when ctrl_idle_i=1.
REQ-023 WAIT_ACK: ctrl_* outputs and grant_o SHALL remain stable until ctrl_ack_i=1.
REQ-024 mN_ack_o SHALL equal ctrl_ack_i AND grant_o[N], combinationally, in the same cycle; the non-granted port never sees ack.
REQ-025 mN_dat_o SHALL be registered: loaded from ctrl_dat_i on the ctrl_ack_i cycle of a port-N read and held until the next port-N read ack; SHALL also be driven with ctrl_dat_i combinationally during that ack cycle.
REQ-026 On ctrl_ack_i in WAIT_ACK: ctrl_acc_o, ctrl_we_o, grant_o SHALL clear at the next edge, the last-grant pointer SHALL update, and the state SHALL return to IDLE.
REQ-027 The arbiter SHALL spend at least one cycle in IDLE between accesses, so a master that drops acc on the edge after its ack is never re-granted.
REQ-028 ctrl_ack_i outside WAIT_ACK SHALL be ignored; no mN_ack_o pulse.
REQ-029 A 16-bit cycle counter SHALL clear on entry to ISSUE and saturate; when TIMEOUT>0 and the count reaches TIMEOUT in WAIT_ACK, timeout_o SHALL set and stay set; the access itself SHALL continue to wait for ack.
REQ-030 mN_acc_i deasserted by a master while granted SHALL NOT abort the access; the arbiter completes it.
REQ-031 ctrl_idle_i=0 in IDLE SHALL block all grants; requests stay pending.

Reset
REQ-032 On sdram_rst=1 at any edge, including mid-access: state=IDLE, ctrl_acc_o=0, ctrl_we_o=0, ctrl_adr_o=0, ctrl_dat_o=0, ctrl_sel_o=0, grant_o=00, mN_dat_o=0, timeout_o=0, counter=0, last-grant pointer=1.
REQ-033 An access interrupted by reset SHALL NOT produce any mN_ack_o after reset.

Verification
REQ-034 Single write: m0 writes adr 0x10, dat 0xA5A5, sel 11 -> ctrl_acc_o rises 2 cycles later with the same fields and grant_o=01; ack -> m0_ack_o pulses once; m1_ack_o stays 0.
REQ-035 Read data: m1 reads adr 0x20, controller returns 0x1234 -> m1_dat_o=0x1234 in the ack cycle and after it; m0_dat_o unchanged.
REQ-036 Contention: both ports request continuously for 4 accesses -> grants alternate 01,10,01,10, starting with 01.
REQ-037 Stall: ctrl_idle_i=0 for 10 cycles while m0 requests -> no ctrl_acc_o; grant 2 cycles after ctrl_idle_i rises.
REQ-038 Timeout: TIMEOUT=8, ack withheld for 20 cycles -> timeout_o=1 from the 8th WAIT_ACK cycle; access completes on the late ack; flag persists.
REQ-039 Reset mid-access: assert sdram_rst during WAIT_ACK, then pulse ctrl_ack_i -> all outputs at reset values; no mN_ack_o pulse.

Source files
------------

// File: rtl/sdram_arbiter.sv
// Two-port round-robin arbiter in front of a single SDRAM controller.
// Latches the winning request, issues it, and routes the completion back to its owner.
module sdram_arbiter #(
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic        sdram_clk,
    input  logic        sdram_rst,

    input  logic        m0_acc_i,
    input  logic        m0_we_i,
    input  logic [31:0] m0_adr_i,
    input  logic [15:0] m0_dat_i,
    input  logic [1:0]  m0_sel_i,
    output logic [15:0] m0_dat_o,
    output logic        m0_ack_o,

    input  logic        m1_acc_i,
    input  logic        m1_we_i,
    input  logic [31:0] m1_adr_i,
    input  logic [15:0] m1_dat_i,
    input  logic [1:0]  m1_sel_i,
    output logic [15:0] m1_dat_o,
    output logic        m1_ack_o,

    input  logic        ctrl_idle_i,
    input  logic        ctrl_ack_i,
    input  logic [15:0] ctrl_dat_i,
    output logic        ctrl_acc_o,
    output logic        ctrl_we_o,
    output logic [31:0] ctrl_adr_o,
    output logic [15:0] ctrl_dat_o,
    output logic [1:0]  ctrl_sel_o,
    output logic [1:0]  grant_o,
    output logic        timeout_o
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_ACK} state_t;

    state_t      state_q, state_d;
    logic        acc_q, acc_d;
    logic        we_q, we_d;
    logic [31:0] adr_q, adr_d;
    logic [15:0] dat_q, dat_d;
    logic [1:0]  sel_q, sel_d;
    logic [1:0]  grant_q, grant_d;
    logic        last_q, last_d;
    logic [15:0] cnt_q, cnt_d;
    logic        tmo_q, tmo_d;
    logic [15:0] m0_rd_q, m0_rd_d;
    logic [15:0] m1_rd_q, m1_rd_d;
    logic        win;
    logic        ack_live;

    // Controller acks are only meaningful while an access is outstanding.
    assign ack_live = ctrl_ack_i && (state_q == WAIT_ACK);

    always_comb begin
        // NOTE: every signal gets its hold value first so no path can infer a latch.
        state_d = state_q;
        acc_d   = acc_q;
        we_d    = we_q;
        adr_d   = adr_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        last_d  = last_q;
        tmo_d   = tmo_q;
        m0_rd_d = m0_rd_q;
        m1_rd_d = m1_rd_q;
        win     = 1'b0;
        cnt_d   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

        case (state_q)
            IDLE: begin
                if (ctrl_idle_i && (m0_acc_i || m1_acc_i)) begin
                    win     = (m0_acc_i && m1_acc_i) ? ~last_q : m1_acc_i;
                    we_d    = win ? m1_we_i  : m0_we_i;
                    adr_d   = win ? m1_adr_i : m0_adr_i;
                    dat_d   = win ? m1_dat_i : m0_dat_i;
                    sel_d   = win ? m1_sel_i : m0_sel_i;
                    grant_d = win ? 2'b10 : 2'b01;
                    cnt_d   = 16'd0;
                    state_d = ISSUE;
                end
            end
            ISSUE: begin
                acc_d   = 1'b1;
                state_d = WAIT_ACK;
            end
            WAIT_ACK: begin
                if (ctrl_ack_i) begin
                    acc_d   = 1'b0;
                    we_d    = 1'b0;
                    grant_d = 2'b00;
                    last_d  = grant_q[1];
                    state_d = IDLE;
                    if (!we_q && grant_q[0]) m0_rd_d = ctrl_dat_i;
                    if (!we_q && grant_q[1]) m1_rd_d = ctrl_dat_i;
                end
            end
            default: state_d = IDLE;
        endcase

        // Flag the cycle the count reaches TIMEOUT while still waiting; the access keeps waiting.
        if ((TIMEOUT != 0) && (32'(cnt_d) >= TIMEOUT) &&
            ((state_q == ISSUE) || (state_q == WAIT_ACK && !ctrl_ack_i)))
            tmo_d = 1'b1;
    end

    always_ff @(posedge sdram_clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (sdram_rst) begin
            state_q <= IDLE;
            acc_q   <= 1'b0;
            we_q    <= 1'b0;
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
            m0_rd_q <= '0;
            m1_rd_q <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            we_q    <= we_d;
            adr_q   <= adr_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            m0_rd_q <= m0_rd_d;
            m1_rd_q <= m1_rd_d;
        end
    end

    assign ctrl_acc_o = acc_q;
    assign ctrl_we_o  = we_q;
    assign ctrl_adr_o = adr_q;
    assign ctrl_dat_o = dat_q;
    assign ctrl_sel_o = sel_q;
    assign grant_o    = grant_q;
    assign timeout_o  = tmo_q;

    assign m0_ack_o = ack_live && grant_q[0];
    assign m1_ack_o = ack_live && grant_q[1];
    assign m0_dat_o = (m0_ack_o && !we_q) ? ctrl_dat_i : m0_rd_q;
    assign m1_dat_o = (m1_ack_o && !we_q) ? ctrl_dat_i : m1_rd_q;

endmodule

// File: tb/tb_sdram_arbiter.sv
// Scoreboard bench for sdram_arbiter: stimulus pushes expected issues/acks,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_sdram_arbiter;

    logic        sdram_clk, sdram_rst;
    logic        m0_acc_i, m0_we_i, m1_acc_i, m1_we_i;
    logic [31:0] m0_adr_i, m1_adr_i;
    logic [15:0] m0_dat_i, m1_dat_i, m0_dat_o, m1_dat_o;
    logic [1:0]  m0_sel_i, m1_sel_i;
    logic        m0_ack_o, m1_ack_o;
    logic        ctrl_idle_i, ctrl_ack_i;
    logic [15:0] ctrl_dat_i, ctrl_dat_o;
    logic        ctrl_acc_o, ctrl_we_o;
    logic [31:0] ctrl_adr_o;
    logic [1:0]  ctrl_sel_o, grant_o;
    logic        timeout_o;

    sdram_arbiter #(.TIMEOUT(8)) dut (
        .sdram_clk(sdram_clk), .sdram_rst(sdram_rst),
        .m0_acc_i(m0_acc_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i),
        .m0_sel_i(m0_sel_i), .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o),
        .m1_acc_i(m1_acc_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i),
        .m1_sel_i(m1_sel_i), .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o),
        .ctrl_idle_i(ctrl_idle_i), .ctrl_ack_i(ctrl_ack_i), .ctrl_dat_i(ctrl_dat_i),
        .ctrl_acc_o(ctrl_acc_o), .ctrl_we_o(ctrl_we_o), .ctrl_adr_o(ctrl_adr_o),
        .ctrl_dat_o(ctrl_dat_o), .ctrl_sel_o(ctrl_sel_o), .grant_o(grant_o),
        .timeout_o(timeout_o)
    );

    typedef struct {
        logic [1:0]  grant;
        logic        we;
        logic [31:0] adr;
        logic [15:0] dat;
        logic [1:0]  sel;
    } iss_t;

    typedef struct {
        logic [1:0]  grant;
        logic        we;
        logic [15:0] rdata;
    } ack_t;

    iss_t iss_q[$];
    ack_t ack_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic acc_prev = 1'b0;

    initial sdram_clk = 1'b0;
    always #5 sdram_clk = ~sdram_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got hang expected finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge sdram_clk);
        #1;
    endtask

    task automatic drive(input int p, input logic acc, input logic we, input logic [31:0] adr,
                         input logic [15:0] dat, input logic [1:0] sel);
        if (p == 0) begin
            m0_acc_i = acc; m0_we_i = we; m0_adr_i = adr; m0_dat_i = dat; m0_sel_i = sel;
        end else begin
            m1_acc_i = acc; m1_we_i = we; m1_adr_i = adr; m1_dat_i = dat; m1_sel_i = sel;
        end
    endtask

    task automatic set_acc(input int p, input logic v);
        if (p == 0) m0_acc_i = v;
        else        m1_acc_i = v;
    endtask

    task automatic expect_access(input int p, input logic we, input logic [31:0] adr,
                                 input logic [15:0] dat, input logic [1:0] sel,
                                 input logic [15:0] rdata, input bit with_ack);
        iss_t ie;
        ack_t ae;
        ie = '{grant: (p == 0) ? 2'b01 : 2'b10, we: we, adr: adr, dat: dat, sel: sel};
        iss_q.push_back(ie);
        if (with_ack) begin
            ae = '{grant: ie.grant, we: we, rdata: rdata};
            ack_q.push_back(ae);
        end
    endtask

    // One complete access from an idle arbiter, with optional controller stall before it.
    task automatic access(input int p, input logic we, input logic [31:0] adr,
                          input logic [15:0] dat, input logic [1:0] sel, input logic [15:0] rdata,
                          input int stall, input int ack_wait, input bit drop_early);
        int bad;
        logic [1:0] g;
        g = (p == 0) ? 2'b01 : 2'b10;
        expect_access(p, we, adr, dat, sel, rdata, 1'b1);
        drive(p, 1'b1, we, adr, dat, sel);
        if (stall > 0) begin
            ctrl_idle_i = 1'b0;
            bad = 0;
            repeat (stall) begin
                tick();
                if (ctrl_acc_o !== 1'b0 || grant_o !== 2'b00) bad++;
            end
            check("stall_no_grant", bad, 0);
            ctrl_idle_i = 1'b1;
        end
        tick();
        check("lat_acc_low", ctrl_acc_o, 0);
        tick();
        check("lat_acc_high", ctrl_acc_o, 1);
        check("lat_grant", grant_o, g);
        if (drop_early) set_acc(p, 1'b0);
        tick(ack_wait);
        ctrl_dat_i = rdata;
        ctrl_ack_i = 1'b1;
        #1;
        check("ack_port", {m1_ack_o, m0_ack_o}, g);
        tick();
        ctrl_ack_i = 1'b0;
        set_acc(p, 1'b0);
        check("post_ack_grant", grant_o, 2'b00);
        check("post_ack_acc", ctrl_acc_o, 0);
        check("post_ack_no_ack", {m1_ack_o, m0_ack_o}, 2'b00);
    endtask

    // Monitor: compares every issue (ctrl_acc_o rise) and every master ack against the queues.
    always @(negedge sdram_clk) begin
        iss_t ie;
        ack_t ae;
        if (!sdram_rst) begin
            if (ctrl_acc_o && !acc_prev) begin
                if (iss_q.size() == 0) check("unexpected_issue", 1, 0);
                else begin
                    ie = iss_q.pop_front();
                    check("issue_grant", grant_o, ie.grant);
                    check("issue_we", ctrl_we_o, ie.we);
                    check("issue_adr", ctrl_adr_o, ie.adr);
                    check("issue_dat", ctrl_dat_o, ie.dat);
                    check("issue_sel", ctrl_sel_o, ie.sel);
                end
            end
            if (m0_ack_o || m1_ack_o) begin
                if (ack_q.size() == 0) check("unexpected_ack", {m1_ack_o, m0_ack_o}, 2'b00);
                else begin
                    ae = ack_q.pop_front();
                    check("ack_owner", {m1_ack_o, m0_ack_o}, ae.grant);
                    if (!ae.we)
                        check("ack_rdata", ae.grant[0] ? m0_dat_o : m1_dat_o, ae.rdata);
                end
            end
        end
        acc_prev = ctrl_acc_o;
    end

    initial begin
        int waited;
        sdram_rst   = 1'b1;
        ctrl_idle_i = 1'b1;
        ctrl_ack_i  = 1'b0;
        ctrl_dat_i  = '0;
        drive(0, 1'b0, 1'b0, '0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0, '0);
        tick(3);
        sdram_rst = 1'b0;

        // Reset state.
        check("rst_acc", ctrl_acc_o, 0);
        check("rst_grant", grant_o, 2'b00);
        check("rst_adr", ctrl_adr_o, 0);
        check("rst_m0_dat", m0_dat_o, 0);
        check("rst_timeout", timeout_o, 0);

        // Single write from m0.
        access(0, 1'b1, 32'h10, 16'hA5A5, 2'b11, 16'h0, 0, 1, 1'b0);

        // Read from m1 returns 0x1234; held afterwards, m0 unchanged.
        access(1, 1'b0, 32'h20, 16'h0, 2'b01, 16'h1234, 0, 1, 1'b0);
        check("m1_dat_hold", m1_dat_o, 16'h1234);
        check("m0_dat_untouched", m0_dat_o, 16'h0);

        // Stray controller ack while idle produces nothing.
        ctrl_ack_i = 1'b1;
        ctrl_dat_i = 16'hDEAD;
        #1;
        check("stray_ack", {m1_ack_o, m0_ack_o}, 2'b00);
        check("stray_dat", m1_dat_o, 16'h1234);
        tick();
        ctrl_ack_i = 1'b0;

        // Controller busy for 10 cycles, then grant 2 cycles after it frees up.
        access(0, 1'b1, 32'h30, 16'h5A5A, 2'b10, 16'h0, 10, 2, 1'b0);

        // Master drops its request while granted; access still completes.
        access(1, 1'b1, 32'h34, 16'h0F0F, 2'b01, 16'h0, 0, 3, 1'b1);

        // Contention: port 0 reads, port 1 writes, both held for four accesses.
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) expect_access(0, 1'b0, 32'h100, 16'h0, 2'b11, 16'hBEEF, 1'b1);
            else            expect_access(1, 1'b1, 32'h200, 16'h7777, 2'b11, 16'h0, 1'b1);
        end
        drive(0, 1'b1, 1'b0, 32'h100, 16'h0, 2'b11);
        drive(1, 1'b1, 1'b1, 32'h200, 16'h7777, 2'b11);
        for (int i = 0; i < 4; i++) begin
            waited = 0;
            while (!ctrl_acc_o && waited < 20) begin
                tick();
                waited++;
            end
            check("contention_issue_seen", ctrl_acc_o, 1);
            check("contention_grant", grant_o, (i % 2 == 0) ? 2'b01 : 2'b10);
            tick();
            ctrl_dat_i = (i % 2 == 0) ? 16'hBEEF : 16'h0;
            ctrl_ack_i = 1'b1;
            tick();
            ctrl_ack_i = 1'b0;
            if (i == 3) begin
                set_acc(0, 1'b0);
                set_acc(1, 1'b0);
            end
        end
        tick(3);
        check("contention_no_extra", ctrl_acc_o, 0);
        check("m0_dat_after_contention", m0_dat_o, 16'hBEEF);

        // Timeout: ack withheld for 20 WAIT_ACK cycles with TIMEOUT=8.
        check("timeout_clear_before", timeout_o, 0);
        expect_access(0, 1'b1, 32'h40, 16'h1111, 2'b11, 16'h0, 1'b1);
        drive(0, 1'b1, 1'b1, 32'h40, 16'h1111, 2'b11);
        tick(2);
        check("tmo_acc_up", ctrl_acc_o, 1);
        tick(6);
        check("tmo_cycle7", timeout_o, 0);
        tick();
        check("tmo_cycle8", timeout_o, 1);
        tick(12);
        check("tmo_still_waiting", grant_o, 2'b01);
        ctrl_ack_i = 1'b1;
        #1;
        check("tmo_late_ack", m0_ack_o, 1);
        tick();
        ctrl_ack_i = 1'b0;
        set_acc(0, 1'b0);
        tick(3);
        check("tmo_sticky", timeout_o, 1);

        // Reset in the middle of an access, then a late controller ack.
        expect_access(0, 1'b0, 32'h50, 16'h0, 2'b01, 16'h0, 1'b0);
        drive(0, 1'b1, 1'b0, 32'h50, 16'h0, 2'b01);
        tick(3);
        check("rst_mid_grant_before", grant_o, 2'b01);
        sdram_rst = 1'b1;
        tick();
        set_acc(0, 1'b0);
        sdram_rst = 1'b0;
        check("rst_mid_acc", ctrl_acc_o, 0);
        check("rst_mid_grant", grant_o, 2'b00);
        check("rst_mid_adr", ctrl_adr_o, 0);
        check("rst_mid_sel", ctrl_sel_o, 0);
        check("rst_mid_m0_dat", m0_dat_o, 0);
        check("rst_mid_m1_dat", m1_dat_o, 0);
        check("rst_mid_timeout", timeout_o, 0);
        ctrl_dat_i = 16'h9999;
        ctrl_ack_i = 1'b1;
        #1;
        check("rst_mid_no_ack", {m1_ack_o, m0_ack_o}, 2'b00);
        tick();
        ctrl_ack_i = 1'b0;
        tick(2);
        check("rst_mid_idle", ctrl_acc_o, 0);

        check("issue_queue_drained", iss_q.size(), 0);
        check("ack_queue_drained", ack_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
